// File: rtl/calendar_pkg.sv
// calendar_pkg: shared month constants, widths and the days-in-month lookup.
package calendar_pkg;
    localparam int MONTH_W = 4;
    localparam int DIM_W   = 6;
    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    function automatic logic [DIM_W-1:0] dim_lookup(input logic [MONTH_W-1:0] m, input logic leap);
        return (m == FEB) ? (leap ? 6'd29 : 6'd28) :
               (m == APR || m == JUN || m == SEP || m == NOV) ? 6'd30 : 6'd31;
    endfunction
endpackage

// File: rtl/leap_year_detect.sv
// leap_year_detect: combinational Gregorian leap-year decode.
module leap_year_detect #(
    parameter int YEAR_W = 12
) (
    input  logic [YEAR_W-1:0] year_i,
    output logic              leap_o
);
    localparam logic [YEAR_W-1:0] C4   = YEAR_W'(4);
    localparam logic [YEAR_W-1:0] C100 = YEAR_W'(100);
    localparam logic [YEAR_W-1:0] C400 = YEAR_W'(400);
    localparam logic [YEAR_W-1:0] Z    = '0;

    assign leap_o = ((year_i % C4) == Z && (year_i % C100) != Z) || (year_i % C400) == Z;
endmodule

// File: rtl/counter_month_year.sv
// counter_month_year: month/year calendar stage fed by the day counter's wrap pulse.
// Returns days-in-month for the current month/year back to the day counter.
module counter_month_year
    import calendar_pkg::*;
#(
    parameter int YEAR_W    = 12,
    parameter int YEAR_MIN  = 2000,
    parameter int YEAR_MAX  = 2099,
    parameter int YEAR_INIT = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carry_in,
    input  logic               inc_month,
    input  logic               dec_month,
    input  logic               inc_year,
    input  logic               dec_year,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic [DIM_W-1:0]   dim,
    output logic               leap,
    output logic               carry_out
);
    localparam logic [YEAR_W-1:0] Y_MIN  = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_INIT = YEAR_W'(YEAR_INIT);
    localparam logic [YEAR_W-1:0] Y_ONE  = YEAR_W'(1);

    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q, year_d;
    logic               carry_q, carry_d;
    logic               manual, auto, m_bad, y_bad, roll_year;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            month_q <= JAN;
            year_q  <= Y_INIT;
            carry_q <= 1'b0;
        end else begin
            month_q <= month_d;
            year_q  <= year_d;
            carry_q <= carry_d;
        end
    end

    // Any manual strobe discards the day-wrap pulse; recovery from an illegal value wins over everything.
    always_comb begin
        manual    = inc_month | dec_month | inc_year | dec_year;
        auto      = carry_in & ~manual;
        m_bad     = (month_q == '0) || (month_q > DEC);
        y_bad     = (year_q < Y_MIN) || (year_q > Y_MAX);
        roll_year = auto & ~m_bad & (month_q == DEC);
        month_d   = month_q;
        year_d    = year_q;
        carry_d   = 1'b0;
        if (m_bad)
            month_d = JAN;
        else if (inc_month ^ dec_month)
            month_d = inc_month ? ((month_q == DEC) ? JAN : month_q + 4'd1)
                                : ((month_q == JAN) ? DEC : month_q - 4'd1);
        else if (auto)
            month_d = (month_q == DEC) ? JAN : month_q + 4'd1;
        if (y_bad)
            year_d = Y_MIN;
        else if (inc_year ^ dec_year)
            year_d = inc_year ? ((year_q == Y_MAX) ? Y_MIN : year_q + Y_ONE)
                              : ((year_q == Y_MIN) ? Y_MAX : year_q - Y_ONE);
        else if (roll_year) begin
            year_d  = (year_q == Y_MAX) ? Y_MIN : year_q + Y_ONE;
            carry_d = (year_q == Y_MAX);
        end
    end

    leap_year_detect #(.YEAR_W(YEAR_W)) u_leap (
        .year_i (year_q),
        .leap_o (leap)
    );

    assign month     = month_q;
    assign year      = year_q;
    assign carry_out = carry_q;
    assign dim       = dim_lookup(month_q, leap);
endmodule

// File: tb/tb_counter_month_year.sv
// tb_counter_month_year: directed checks of month/year counting, wraps, collisions and recovery.
module tb_counter_month_year;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  s1 = '0;
    logic [4:0]  s2 = '0;
    logic [3:0]  month1, month2;
    logic [11:0] year1, year2;
    logic [5:0]  dim1, dim2;
    logic        leap1, leap2, co1, co2;
    int          n = 0;
    int          miss = 0;

    localparam logic [4:0] C  = 5'b10000;
    localparam logic [4:0] IM = 5'b01000;
    localparam logic [4:0] DM = 5'b00100;
    localparam logic [4:0] IY = 5'b00010;
    localparam logic [4:0] DY = 5'b00001;
    localparam logic [4:0] NO = 5'b00000;

    always #5 clk = ~clk;

    counter_month_year dut (
        .clk(clk), .rst_n(rst_n),
        .carry_in(s1[4]), .inc_month(s1[3]), .dec_month(s1[2]), .inc_year(s1[1]), .dec_year(s1[0]),
        .month(month1), .year(year1), .dim(dim1), .leap(leap1), .carry_out(co1)
    );

    counter_month_year #(.YEAR_MAX(2400)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .carry_in(s2[4]), .inc_month(s2[3]), .dec_month(s2[2]), .inc_year(s2[1]), .dec_year(s2[0]),
        .month(month2), .year(year2), .dim(dim2), .leap(leap2), .carry_out(co2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [4:0] a, input logic [4:0] b);
        s1 = a;
        s2 = b;
        @(negedge clk);
        s1 = NO;
        s2 = NO;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_month", 32'(month1), 1);
        chk("rst_year", 32'(year1), 2000);
        chk("rst_leap", 32'(leap1), 1);
        chk("rst_dim", 32'(dim1), 31);
        chk("rst_carry", 32'(co1), 0);

        step(IM, IM);
        for (int k = 0; k < 23; k++) step(IY, NO);
        chk("2023feb_dim", 32'(dim1), 28);
        chk("2023feb_leap", 32'(leap1), 0);
        step(C, NO);
        chk("2023_auto_month", 32'(month1), 3);
        chk("2023_auto_dim", 32'(dim1), 31);
        chk("2023_auto_year", 32'(year1), 2023);
        step(IY, NO);
        step(DM, NO);
        chk("2024feb_dim", 32'(dim1), 29);
        step(C, NO);
        chk("2024_auto_month", 32'(month1), 3);
        chk("2024_auto_dim", 32'(dim1), 31);

        chk("y2000feb_dim", 32'(dim2), 29);
        step(NO, DY);
        chk("y2400_year", 32'(year2), 2400);
        chk("y2400feb_dim", 32'(dim2), 29);
        step(NO, IY);
        chk("y2400_wrap_up", 32'(year2), 2000);
        for (int k = 0; k < 23; k++) step(NO, IY);
        chk("y2023feb_dim", 32'(dim2), 28);
        for (int k = 0; k < 77; k++) step(NO, IY);
        chk("y2100_year", 32'(year2), 2100);
        chk("y2100feb_dim", 32'(dim2), 28);
        chk("y2100_leap", 32'(leap2), 0);

        for (int k = 0; k < 75; k++) step(IY, NO);
        for (int k = 0; k < 9; k++) step(IM, NO);
        chk("set_2099_year", 32'(year1), 2099);
        chk("set_12_month", 32'(month1), 12);
        chk("pre_wrap_carry", 32'(co1), 0);
        step(C, NO);
        chk("wrap_month", 32'(month1), 1);
        chk("wrap_year", 32'(year1), 2000);
        chk("wrap_carry_hi", 32'(co1), 1);
        step(NO, NO);
        chk("wrap_carry_lo", 32'(co1), 0);

        step(DM, NO);
        chk("dec_month_wrap", 32'(month1), 12);
        chk("dec_month_year", 32'(year1), 2000);
        step(IM, NO);
        chk("inc_month_wrap", 32'(month1), 1);
        chk("inc_month_year", 32'(year1), 2000);
        chk("inc_month_carry", 32'(co1), 0);
        step(NO, NO);
        step(DY, NO);
        chk("dec_year_wrap", 32'(year1), 2099);
        step(IY, NO);
        chk("inc_year_wrap", 32'(year1), 2000);
        chk("inc_year_carry", 32'(co1), 0);

        for (int k = 0; k < 4; k++) step(IM, NO);
        step(C | IM, NO);
        chk("cin_incm_month", 32'(month1), 6);
        step(IY | DY, NO);
        chk("incy_decy_year", 32'(year1), 2000);
        step(IM | DM, NO);
        chk("incm_decm_month", 32'(month1), 6);
        step(IM | IY, NO);
        chk("m_y_both_month", 32'(month1), 7);
        chk("m_y_both_year", 32'(year1), 2001);
        step(C | IY, NO);
        chk("cin_dropped_month", 32'(month1), 7);
        chk("cin_dropped_year", 32'(year1), 2002);

        force dut.month_q = 4'd13;
        #1 release dut.month_q;
        @(negedge clk);
        chk("recover_month", 32'(month1), 1);
        force dut.year_q = 12'd3000;
        #1 release dut.year_q;
        @(negedge clk);
        chk("recover_year", 32'(year1), 2000);
        step(IM | IY, NO);

        s1 = C;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_month", 32'(month1), 1);
        chk("async_rst_year", 32'(year1), 2000);
        chk("async_rst_carry", 32'(co1), 0);
        @(negedge clk);
        s1 = NO;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_month", 32'(month1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n, miss);
        $finish;
    end
endmodule
